// File: rtl/ctrl_pkg.sv
// Shared types for the registered control decoder: opcode/subop encodings, FSM states and
// the decoded control-field bundle produced by ctrl_field_decode.
package ctrl_pkg;

    typedef enum logic [2:0] {
        OpAlu0    = 3'b000,
        OpAlu1    = 3'b001,
        OpMem     = 3'b010,
        OpSet     = 3'b011,
        OpMoveIn  = 3'b100,
        OpMoveOut = 3'b101,
        OpBranch  = 3'b110,
        OpSys     = 3'b111
    } opcode_e;

    // Subop encodings under OpMem; 2'b00 decodes as a plain ALU op
    localparam logic [1:0] SubInplace = 2'b01;
    localparam logic [1:0] SubLoad    = 2'b10;
    localparam logic [1:0] SubStore   = 2'b11;

    typedef enum logic [1:0] {
        StRun     = 2'b00,
        StMemWait = 2'b01,
        StHalted  = 2'b10
    } state_e;

    // Width-independent decode flags; register selects travel as separate ports
    typedef struct packed {
        logic load;
        logic store;
        logic branch;
        logic halt;
        logic imm;
        logic inplace;
        logic move;
        logic reg_write;
    } ctrl_t;

endpackage

// File: rtl/ctrl_field_decode.sv
// Combinational instruction field decoder: Instr -> ctrl_t flags plus register/target selects.
// Branch direction is not resolved here; the sequencer applies Eq at acceptance.
module ctrl_field_decode
    import ctrl_pkg::*;
#(
    parameter int unsigned IW  = 9,
    parameter int unsigned RSW = 4,
    parameter int unsigned TW  = 6
) (
    input  logic [IW-1:0]  i_instr,
    output ctrl_t          o_ctrl,
    output logic [RSW-1:0] o_reg_sel,
    output logic [RSW-1:0] o_move_from,
    output logic [TW-1:0]  o_targ_sel
);

    opcode_e    w_opcode;
    logic [1:0] w_subop;

    assign w_opcode = opcode_e'(i_instr[IW-1 -: 3]);
    assign w_subop  = i_instr[IW-4 -: 2];

    // Field decode; all-ones word is halt and overrides the opcode table
    always_comb begin
        o_ctrl      = '0;
        o_reg_sel   = i_instr[RSW-1:0];
        o_move_from = '0;
        o_targ_sel  = '0;
        if (&i_instr) begin
            o_ctrl.halt = 1'b1;
            o_reg_sel   = '0;
        end else begin
            case (w_opcode)
                OpMem: begin
                    case (w_subop)
                        SubLoad: begin
                            o_ctrl.load      = 1'b1;
                            o_ctrl.reg_write = 1'b1;
                        end
                        SubStore:   o_ctrl.store = 1'b1;
                        SubInplace: begin
                            o_ctrl.inplace   = 1'b1;
                            o_ctrl.reg_write = 1'b1;
                        end
                        default:    o_ctrl.reg_write = 1'b1;
                    endcase
                end
                OpSet: begin
                    o_ctrl.imm       = 1'b1;
                    o_ctrl.reg_write = 1'b1;
                    o_reg_sel        = '0;
                end
                // Move-in copies the selected register into R0
                OpMoveIn: begin
                    o_ctrl.move      = 1'b1;
                    o_ctrl.reg_write = 1'b1;
                    o_reg_sel        = '0;
                    o_move_from      = i_instr[RSW-1:0];
                end
                // Move-out copies R0 into the selected register
                OpMoveOut: begin
                    o_ctrl.move      = 1'b1;
                    o_ctrl.reg_write = 1'b1;
                end
                OpBranch: begin
                    o_ctrl.branch = 1'b1;
                    o_reg_sel     = '0;
                    o_targ_sel    = i_instr[TW-1:0];
                end
                default: o_ctrl.reg_write = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/ctrl_seq_decoder.sv
// Registered control decoder with memory req/ack sequencing and sticky halt.
// Optional performance counters (RetireCnt, BranchCnt) when CTRL_PERF_CNT_EN is defined.
module ctrl_seq_decoder
    import ctrl_pkg::*;
#(
    parameter int unsigned IW  = 9,
    parameter int unsigned RSW = 4,
    parameter int unsigned TW  = 6
`ifdef CTRL_PERF_CNT_EN
    ,
    parameter int unsigned CNT_W = 16
`endif
) (
    input  logic           i_clk,
    input  logic           i_reset_n,
    input  logic [IW-1:0]  i_instr,
    input  logic           i_instr_valid,
    output logic           o_instr_ready,
    input  logic           i_eq,
    output logic           o_mem_req,
    input  logic           i_mem_ack,
    output logic           o_ctrl_valid,
    output logic           o_branch_en,
    output logic           o_mem_read,
    output logic           o_mem_write,
    output logic           o_imm,
    output logic           o_reg_write,
    output logic           o_inplace,
    output logic           o_move,
    output logic [RSW-1:0] o_reg_sel,
    output logic [RSW-1:0] o_move_from,
    output logic [TW-1:0]  o_targ_sel,
    output logic           o_halt
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] o_retire_cnt,
    output logic [CNT_W-1:0] o_branch_cnt
`endif
);

    ctrl_t          w_dec;
    logic [RSW-1:0] w_dec_reg_sel, w_dec_move_from;
    logic [TW-1:0]  w_dec_targ_sel;
    logic           w_accept, w_taken;

    state_e         r_state, w_state;
    logic           r_ready, w_ready;
    logic           r_ctrl_valid, w_ctrl_valid;
    logic           r_branch_en, w_branch_en;
    logic           r_mem_read, w_mem_read;
    logic           r_mem_write, w_mem_write;
    logic           r_imm, w_imm;
    logic           r_reg_write, w_reg_write;
    logic           r_inplace, w_inplace;
    logic           r_move, w_move;
    logic [RSW-1:0] r_reg_sel, w_reg_sel;
    logic [RSW-1:0] r_move_from, w_move_from;
    logic [TW-1:0]  r_targ_sel, w_targ_sel;
    logic [RSW-1:0] r_pend_sel, w_pend_sel;

    ctrl_field_decode #(
        .IW  (IW),
        .RSW (RSW),
        .TW  (TW)
    ) u_decode (
        .i_instr     (i_instr),
        .o_ctrl      (w_dec),
        .o_reg_sel   (w_dec_reg_sel),
        .o_move_from (w_dec_move_from),
        .o_targ_sel  (w_dec_targ_sel)
    );

    assign w_accept = i_instr_valid & r_ready;
    assign w_taken  = w_dec.branch & ~i_eq;

    // Next-state and next-control; every control bit defaults to 0 so it drops without CtrlValid
    always_comb begin
        w_state      = r_state;
        w_ctrl_valid = 1'b0;
        w_branch_en  = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_imm        = 1'b0;
        w_reg_write  = 1'b0;
        w_inplace    = 1'b0;
        w_move       = 1'b0;
        w_reg_sel    = '0;
        w_move_from  = '0;
        w_targ_sel   = '0;
        w_pend_sel   = r_pend_sel;
        unique case (r_state)
            StRun: begin
                if (w_accept) begin
                    if (w_dec.halt) begin
                        w_state = StHalted;
                    end else if (w_dec.load || w_dec.store) begin
                        w_state     = StMemWait;
                        w_mem_read  = w_dec.load;
                        w_mem_write = w_dec.store;
                        w_pend_sel  = w_dec_reg_sel;
                    end else begin
                        w_ctrl_valid = 1'b1;
                        w_branch_en  = w_taken;
                        w_imm        = w_dec.imm;
                        w_inplace    = w_dec.inplace;
                        w_move       = w_dec.move;
                        // A not-taken branch still retires with a register write
                        w_reg_write  = w_dec.reg_write | (w_dec.branch & i_eq);
                        w_reg_sel    = w_dec_reg_sel;
                        w_move_from  = w_dec_move_from;
                        w_targ_sel   = w_taken ? w_dec_targ_sel : '0;
                    end
                end
            end
            StMemWait: begin
                w_mem_read  = r_mem_read;
                w_mem_write = r_mem_write;
                if (i_mem_ack) begin
                    w_state      = StRun;
                    w_ctrl_valid = 1'b1;
                    w_reg_write  = r_mem_read;
                    w_reg_sel    = r_pend_sel;
                end
            end
            StHalted: w_state = StHalted;
            default:  w_state = StRun;
        endcase
        w_ready = (w_state == StRun);
    end

    // State and registered control outputs
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= StRun;
            r_ready      <= 1'b0;
            r_ctrl_valid <= 1'b0;
            r_branch_en  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_imm        <= 1'b0;
            r_reg_write  <= 1'b0;
            r_inplace    <= 1'b0;
            r_move       <= 1'b0;
            r_reg_sel    <= '0;
            r_move_from  <= '0;
            r_targ_sel   <= '0;
            r_pend_sel   <= '0;
        end else begin
            r_state      <= w_state;
            r_ready      <= w_ready;
            r_ctrl_valid <= w_ctrl_valid;
            r_branch_en  <= w_branch_en;
            r_mem_read   <= w_mem_read;
            r_mem_write  <= w_mem_write;
            r_imm        <= w_imm;
            r_reg_write  <= w_reg_write;
            r_inplace    <= w_inplace;
            r_move       <= w_move;
            r_reg_sel    <= w_reg_sel;
            r_move_from  <= w_move_from;
            r_targ_sel   <= w_targ_sel;
            r_pend_sel   <= w_pend_sel;
        end
    end

`ifdef CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] r_retire_cnt, r_branch_cnt;

    // Retire/taken-branch counters, wrapping, frozen once halted
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_retire_cnt <= '0;
            r_branch_cnt <= '0;
        end else if (r_state != StHalted) begin
            if (r_ctrl_valid) r_retire_cnt <= r_retire_cnt + 1'b1;
            if (r_ctrl_valid && r_branch_en) r_branch_cnt <= r_branch_cnt + 1'b1;
        end
    end

    assign o_retire_cnt = r_retire_cnt;
    assign o_branch_cnt = r_branch_cnt;
`endif

    assign o_instr_ready = r_ready;
    assign o_mem_req     = (r_state == StMemWait);
    assign o_halt        = (r_state == StHalted);
    assign o_ctrl_valid  = r_ctrl_valid;
    assign o_branch_en   = r_branch_en;
    assign o_mem_read    = r_mem_read;
    assign o_mem_write   = r_mem_write;
    assign o_imm         = r_imm;
    assign o_reg_write   = r_reg_write;
    assign o_inplace     = r_inplace;
    assign o_move        = r_move;
    assign o_reg_sel     = r_reg_sel;
    assign o_move_from   = r_move_from;
    assign o_targ_sel    = r_targ_sel;

endmodule
